// File: rtl/div_ctrl.sv
// Sequencing controller for an iterative 32-bit divider; owns the
// architectural HI/LO registers and a watchdog on the iterate phase.
module div_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  DivtoControl,
  input  logic [31:0] DivHi,
  input  logic [31:0] DivLo,
  input  logic [31:0] MtWrData,
  input  logic        MtHi,
  input  logic        MtLo,
  output logic [1:0]  DivState,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic        Timeout,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_EVAL, S_INIT, S_ITER, S_FINAL, S_WRITE
  } state_t;

  localparam logic [1:0] ST_OK   = 2'b01;
  localparam logic [1:0] ST_ZERO = 2'b10;
  localparam logic [5:0] WD_MAX  = 6'd40;

  state_t      r_state;
  logic [5:0]  r_wd;
  logic        r_done, r_divzero, r_timeout;
  logic [31:0] r_hi, r_lo;

  logic [5:0]  w_wd_inc;
  logic        w_fin;

  assign w_wd_inc = r_wd + 6'd1;
  // Finalize is issued in the same cycle the divider reports completion,
  // so the divider never sees an extra iterate edge.
  assign w_fin    = (r_state == S_ITER) && (DivtoControl == ST_OK);

  always_comb begin
    DivState = 2'b00;
    case (r_state)
      S_INIT:  DivState = 2'b01;
      S_ITER:  DivState = w_fin ? 2'b11 : 2'b10;
      S_FINAL: DivState = 2'b11;
      default: DivState = 2'b00;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_wd      <= 6'd0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_timeout <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_timeout <= 1'b0;

      // A divider result being committed takes priority over move-to writes.
      if (r_state == S_WRITE) begin
        r_hi <= DivHi;
        r_lo <= DivLo;
      end else begin
        if (MtHi) r_hi <= MtWrData;
        if (MtLo) r_lo <= MtWrData;
      end

      case (r_state)
        S_IDLE:  if (Start) r_state <= S_CHECK;
        S_CHECK: r_state <= S_EVAL;
        S_EVAL: begin
          if (DivtoControl == ST_ZERO) begin
            r_state   <= S_IDLE;
            r_divzero <= 1'b1;
          end else begin
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_state <= S_ITER;
          r_wd    <= 6'd0;
        end
        S_ITER: begin
          r_wd <= w_wd_inc;
          if (w_fin) begin
            r_state <= S_WRITE;
          end else if (w_wd_inc == WD_MAX) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end
        end
        S_FINAL: r_state <= S_WRITE;
        S_WRITE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy    = (r_state != S_IDLE);
  assign Done    = r_done;
  assign DivZero = r_divzero;
  assign Timeout = r_timeout;
  assign HiOut   = r_hi;
  assign LoOut   = r_lo;

endmodule
